// File: rtl/servo_pwm_capture.sv
`timescale 1ns/1ps
// Measures high time and rise-to-rise period of a servo PWM input; publishes on each frame-ending rise.
// Latency: 3 edges from pwm_in rise to sample_valid. No backpressure; a timeout flags loss of signal.
module servo_pwm_capture #(
  parameter int unsigned MIN_WIDTH  = 50000,
  parameter int unsigned MAX_WIDTH  = 250000,
  parameter int unsigned MIN_PERIOD = 1000000,
  parameter int unsigned MAX_PERIOD = 4000000
) (
  input  logic        clock_clk,
  input  logic        reset_low,
  input  logic        pwm_in,
  output logic [31:0] width_out,
  output logic [31:0] period_out,
  output logic        sample_valid,
  output logic        in_range,
  output logic        signal_lost
);

  localparam logic [31:0] MIN_W = 32'(MIN_WIDTH);
  localparam logic [31:0] MAX_W = 32'(MAX_WIDTH);
  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);
  localparam logic [31:0] MAX_P = 32'(MAX_PERIOD);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      state, state_nxt;
  logic        sync_a, sync, prev;
  logic        rise, fall;
  logic [31:0] width_cnt, period_cnt, width_nxt, period_nxt;
  logic        publish, timeout;
  logic        range_ok;

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      sync_a <= 1'b0;
      sync   <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_a <= pwm_in;
      sync   <= sync_a;
      prev   <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

  assign range_ok = (width_cnt >= MIN_W) && (width_cnt <= MAX_W) &&
                    (period_cnt >= MIN_P) && (period_cnt <= MAX_P);

  // Timeout is tested before any increment so the counters stop at MAX_P.
  always_comb begin
    state_nxt  = state;
    width_nxt  = width_cnt;
    period_nxt = period_cnt;
    publish    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt  = HIGH;
          width_nxt  = 32'd1;
          period_nxt = 32'd1;
        end
      end
      HIGH: begin
        if (period_cnt >= MAX_P) begin
          timeout    = 1'b1;
          state_nxt  = IDLE;
          width_nxt  = '0;
          period_nxt = '0;
        end else if (fall) begin
          state_nxt  = LOW;
          period_nxt = period_cnt + 32'd1;
        end else begin
          width_nxt  = width_cnt + 32'd1;
          period_nxt = period_cnt + 32'd1;
        end
      end
      LOW: begin
        if (rise) begin
          publish    = 1'b1;
          state_nxt  = HIGH;
          width_nxt  = 32'd1;
          period_nxt = 32'd1;
        end else if (period_cnt >= MAX_P) begin
          timeout    = 1'b1;
          state_nxt  = IDLE;
          width_nxt  = '0;
          period_nxt = '0;
        end else begin
          period_nxt = period_cnt + 32'd1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        width_nxt  = '0;
        period_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state      <= IDLE;
      width_cnt  <= '0;
      period_cnt <= '0;
    end else begin
      state      <= state_nxt;
      width_cnt  <= width_nxt;
      period_cnt <= period_nxt;
    end
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      width_out    <= '0;
      period_out   <= '0;
      sample_valid <= 1'b0;
      in_range     <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      sample_valid <= publish;
      if (publish) begin
        width_out   <= width_cnt;
        period_out  <= period_cnt;
        in_range    <= range_ok;
        signal_lost <= 1'b0;
      end else if (timeout) begin
        signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: doc/servo_pwm_capture.md
SERVO_PWM_CAPTURE -- requirements
Module: servo_pwm_capture

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MIN_WIDTH, default 50000, giving the minimum in-range high time in clocks (0.5 ms at 100 MHz).
REQ-002 The block SHALL have parameter MAX_WIDTH, default 250000, giving the maximum in-range high time in clocks (2.5 ms).
REQ-003 The block SHALL have parameter MIN_PERIOD, default 1000000, giving the minimum in-range rise-to-rise period in clocks (10 ms).
REQ-004 The block SHALL have parameter MAX_PERIOD, default 4000000, giving the maximum in-range period and the loss-of-signal timeout in clocks (40 ms).

Ports (name, direction, width, meaning):
REQ-005 clock_clk, input, 1: system clock (100 MHz).
REQ-006 reset_low, input, 1: reset, asynchronous, active-low.
REQ-007 pwm_in, input, 1: asynchronous servo-style PWM input.
REQ-008 width_out, output, 32: last published high time, in clocks.
REQ-009 period_out, output, 32: last published rise-to-rise period, in clocks.
REQ-010 sample_valid, output, 1: one-cycle strobe marking a new publication.
REQ-011 in_range, output, 1: the published sample meets all four limits.
REQ-012 signal_lost, output, 1: no valid frame is currently being received.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer; all measurement SHALL use the synchronized signal (sync) and its registered previous value.
- rise = sync & ~prev
- fall = ~sync & prev
REQ-014 The FSM SHALL have exactly these states: IDLE, HIGH, LOW.
REQ-015 IDLE behaviour:
- ignores everything except rise;
- on rise: go to HIGH, width_cnt <= 1, period_cnt <= 1;
- any partial pulse present when IDLE is entered SHALL be discarded.
REQ-016 HIGH behaviour:
- each cycle with sync=1: width_cnt and period_cnt each increment by 1;
- on fall: go to LOW and increment period_cnt only.
REQ-017 LOW behaviour:
- each cycle with sync=0: period_cnt increments;
- on rise: publish, then restart with width_cnt <= 1, period_cnt <= 1, and go to HIGH.
REQ-018 Publication SHALL take effect on the clock edge of the LOW->HIGH transition, all in that one edge:
- width_out <= width_cnt;
- period_out <= period_cnt;
- in_range <= (MIN_WIDTH <= width_cnt <= MAX_WIDTH) && (MIN_PERIOD <= period_cnt <= MAX_PERIOD);
- sample_valid <= 1;
- signal_lost <= 0.
REQ-019 sample_valid SHALL be high for exactly one cycle per publication and low otherwise.
REQ-020 A sync high of N cycles SHALL publish width N, and a sync rise-to-rise of P cycles SHALL publish period P, with no off-by-one.
REQ-021 Latency SHALL be fixed: sample_valid asserts 3 clock edges after the pwm_in rising edge that ends the frame (2 synchronizer stages + 1 publish).
REQ-022 Out-of-range samples SHALL still be published, with in_range=0.
REQ-023 Timeout: if period_cnt reaches MAX_PERIOD in HIGH or LOW without a rise, the block SHALL, on the next edge:
- go to IDLE;
- set signal_lost <= 1;
- not strobe sample_valid;
- hold width_out, period_out and in_range.
REQ-024 Timeout SHALL cover stuck-high (0 %/100 % duty) inputs.
REQ-025 Counters SHALL never wrap: the timeout check precedes any increment beyond MAX_PERIOD.
REQ-026 When rise and timeout occur in the same cycle, the rise SHALL take priority and publish.
REQ-027 The first rise after reset or after a timeout SHALL only start measurement; the first publication SHALL occur on the second rise.

Reset
REQ-028 While reset_low=0, asynchronously, the block SHALL clear:
- FSM to IDLE;
- synchronizer flops, prev, width_cnt and period_cnt to 0;
- width_out, period_out, sample_valid and in_range to 0;
- and SHALL set signal_lost to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no publication; after release, operation SHALL resume per REQ-027.

Verification
REQ-030 Nominal: three frames, high 165000 / period 2000000 -> two sample_valid pulses, each with width_out=165000, period_out=2000000, in_range=1, signal_lost=0.
REQ-031 Short pulse: high 30000 / period 2000000 -> published width_out=30000, in_range=0, sample_valid still pulses.
REQ-032 Loss, stuck low: after a nominal frame, hold pwm_in=0 -> signal_lost=1 exactly MAX_PERIOD+1 edges after the last synchronized rise, no strobe, outputs held at 165000/2000000.
REQ-033 Loss, stuck high: hold pwm_in=1 after a rise -> signal_lost=1 at the same timing as REQ-032; the following rise starts a frame but does not publish.
REQ-034 Reset mid-HIGH (reset_low=0 for 5 cycles at cycle 80000 of a pulse) -> all outputs at reset values; the first post-reset strobe occurs on the second full rise with exact values.
REQ-035 Glitch: a single-cycle high pulse inside a 2000000-cycle frame -> width_out=1, in_range=0, and the period is measured from the glitch rise.
